// File: rtl/btn_debounce.sv
// Two-button debouncer with press and auto-repeat pulse generation.
// Latency: level and first pulse at 2+DB_CYCLES edges after a clean raw edge; no backpressure.

// One button: synchronizer, debounce counter and press/hold/repeat FSM.
// Latency: stable level and first pulse request at 2+DB_CYCLES edges.
// No backpressure: fire is a combinational strobe registered by the parent.
module btn_debounce_chan #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic level_d,
  output logic fire
);

  localparam logic [15:0] DB_LAST   = 16'(DB_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 16'd0 : 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [1:0]  sync_q;
  logic        sync;
  logic [15:0] db_cnt_q;
  logic [15:0] db_cnt_d;
  logic        accept;
  logic        rise;
  logic        fall;
  state_t      state_q;
  state_t      state_d;
  logic [15:0] rep_cnt_q;
  logic [15:0] rep_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign sync = sync_q[1];

  // Any agreement between sync and the stable level restarts the count.
  always_comb begin
    db_cnt_d = 16'd0;
    level_d  = level;
    accept   = 1'b0;
    if (sync != level) begin
      if (db_cnt_q == DB_LAST) begin
        accept  = 1'b1;
        level_d = sync;
      end else begin
        db_cnt_d = db_cnt_q + 16'd1;
      end
    end
  end

  assign rise = accept & sync;
  assign fall = accept & ~sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level    <= 1'b0;
      db_cnt_q <= 16'd0;
    end else begin
      level    <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // The FSM reacts to the accept event itself so the pulse lands on the same edge as the level.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    fire      = 1'b0;
    unique case (state_q)
      IDLE: begin
        rep_cnt_d = 16'd0;
        if (rise) begin
          fire    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fall) begin
          state_d   = IDLE;
          rep_cnt_d = 16'd0;
        end else if (HOLD_CYCLES == 0) begin
          rep_cnt_d = 16'd0;
        end else if (rep_cnt_q == HOLD_LAST) begin
          fire      = 1'b1;
          rep_cnt_d = 16'd0;
          state_d   = REPEAT;
        end else begin
          rep_cnt_d = rep_cnt_q + 16'd1;
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d   = IDLE;
          rep_cnt_d = 16'd0;
        end else if (rep_cnt_q == REP_LAST) begin
          fire      = 1'b1;
          rep_cnt_d = 16'd0;
        end else begin
          rep_cnt_d = rep_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rep_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// Increment/decrement button front end for the PWM stage.
// Latency: level and first pulse at 2+DB_CYCLES edges after a clean raw edge.
// No backpressure: pulses are dropped, never queued, while both buttons are held.
module btn_debounce #(
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_incr_raw,
  input  logic btn_decr_raw,
  output logic incr_pulse,
  output logic decr_pulse,
  output logic incr_level,
  output logic decr_level
);

  logic incr_level_d;
  logic decr_level_d;
  logic incr_fire;
  logic decr_fire;
  logic conflict;

  btn_debounce_chan #(
    .DB_CYCLES     (DB_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_incr (
    .clk     (clk),
    .reset   (reset),
    .raw     (btn_incr_raw),
    .level   (incr_level),
    .level_d (incr_level_d),
    .fire    (incr_fire)
  );

  btn_debounce_chan #(
    .DB_CYCLES     (DB_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_decr (
    .clk     (clk),
    .reset   (reset),
    .raw     (btn_decr_raw),
    .level   (decr_level),
    .level_d (decr_level_d),
    .fire    (decr_fire)
  );

  // Judged on the levels that become visible on this edge, so no pulse ever coexists with two lit LEDs.
  assign conflict = incr_level_d & decr_level_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      incr_pulse <= 1'b0;
      decr_pulse <= 1'b0;
    end else begin
      incr_pulse <= incr_fire & ~conflict;
      decr_pulse <= decr_fire & ~conflict;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: segment table, hand-written corner sequences, and random raw inputs
// checked against an edge-indexed model built from the debounce/repeat rules.
module tb_btn_debounce;

  localparam int DB  = 4;
  localparam int HLD = 16;
  localparam int REP = 8;
  localparam int NR  = 3000;

  logic clk = 1'b0;
  logic reset;
  logic btn_incr_raw;
  logic btn_decr_raw;
  logic incr_pulse;
  logic decr_pulse;
  logic incr_level;
  logic decr_level;

  int total = 0;
  int bad   = 0;

  btn_debounce #(
    .DB_CYCLES     (DB),
    .HOLD_CYCLES   (HLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_incr_raw (btn_incr_raw),
    .btn_decr_raw (btn_decr_raw),
    .incr_pulse   (incr_pulse),
    .decr_pulse   (decr_pulse),
    .incr_level   (incr_level),
    .decr_level   (decr_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic inc;
    logic dec;
    int   len;
    int   exp_ip;
    int   exp_dp;
    logic exp_il;
    logic exp_dl;
  } seg_t;

  seg_t segs[6];
  int   hold_exp[6];

  logic rr[2][NR+1];
  bit   m_stable[2];
  int   m_last_acc[2];
  int   m_press[2];
  bit   m_pulse[2];
  int   hold_left[2];
  logic cur[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    btn_incr_raw = 1'b0;
    btn_decr_raw = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  initial begin
    int ip;
    int dp;
    int first_k;
    int cnt;
    bit e;
    bit all_diff;
    int j;
    logic s;

    // Each segment continues from the previous one; edges counted from reset release.
    segs[0] = '{1'b1, 1'b0, 10, 1, 0, 1'b1, 1'b0};  // press at 6
    segs[1] = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0};  // release at 16
    segs[2] = '{1'b0, 1'b1, 30, 0, 3, 1'b0, 1'b1};  // decr 26, 42, 50
    segs[3] = '{1'b1, 1'b1, 20, 0, 0, 1'b1, 1'b1};  // incr press 56 muted, decr 58, 66 muted
    segs[4] = '{1'b1, 1'b0, 30, 3, 0, 1'b1, 1'b0};  // decr falls 76; incr 72 muted, 80, 88, 96
    segs[5] = '{1'b0, 1'b0, 12, 1, 0, 1'b0, 1'b0};  // incr 104, falls 106
    hold_exp = '{6, 22, 30, 38, 46, 54};

    // Reset with random raw inputs, then one cycle with raw low.
    reset        = 1'b1;
    btn_incr_raw = 1'b0;
    btn_decr_raw = 1'b0;
    #1;
    chk("reset async outs", {incr_pulse, decr_pulse, incr_level, decr_level}, 0);
    for (int c = 0; c < 6; c++) begin
      btn_incr_raw = 1'($urandom_range(0, 1));
      btn_decr_raw = 1'($urandom_range(0, 1));
      step();
      chk("reset held outs", {incr_pulse, decr_pulse, incr_level, decr_level}, 0);
    end
    btn_incr_raw = 1'b0;
    btn_decr_raw = 1'b0;
    reset        = 1'b0;
    step();
    chk("post reset outs", {incr_pulse, decr_pulse, incr_level, decr_level}, 0);

    // Segment table.
    do_reset();
    foreach (segs[i]) begin
      ip = 0;
      dp = 0;
      btn_incr_raw = segs[i].inc;
      btn_decr_raw = segs[i].dec;
      for (int c = 0; c < segs[i].len; c++) begin
        step();
        ip += int'(incr_pulse);
        dp += int'(decr_pulse);
      end
      chk($sformatf("seg%0d incr pulses", i), ip, segs[i].exp_ip);
      chk($sformatf("seg%0d decr pulses", i), dp, segs[i].exp_dp);
      chk($sformatf("seg%0d incr level", i), incr_level, segs[i].exp_il);
      chk($sformatf("seg%0d decr level", i), decr_level, segs[i].exp_dl);
    end

    // Clean press then release.
    do_reset();
    btn_incr_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("press incr_pulse e%0d", k), incr_pulse, k == 6);
      chk($sformatf("press incr_level e%0d", k), incr_level, k >= 6);
      chk($sformatf("press decr e%0d", k), {decr_pulse, decr_level}, 0);
    end
    btn_incr_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("release incr_level e%0d", k), incr_level, k < 6);
      chk($sformatf("release incr_pulse e%0d", k), incr_pulse, 0);
    end

    // Bounce: 2-cycle toggles are never accepted; one pulse 6 edges after the final rise.
    do_reset();
    cnt = 0;
    first_k = -1;
    for (int c = 0; c < 20; c++) begin
      btn_incr_raw = ((c / 2) % 2) == 0;
      step();
      cnt += int'(incr_pulse);
    end
    chk("bounce level before final rise", incr_level, 0);
    btn_incr_raw = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (incr_pulse && first_k < 0) first_k = k;
      cnt += int'(incr_pulse);
    end
    chk("bounce pulse count", cnt, 1);
    chk("bounce pulse edge", first_k, 6);

    // Hold: release lands on the edge after the last listed pulse and before the next one.
    do_reset();
    btn_decr_raw = 1'b1;
    for (int k = 1; k <= 86; k++) begin
      if (k == 57) btn_decr_raw = 1'b0;
      step();
      e = 1'b0;
      foreach (hold_exp[i]) if (hold_exp[i] == k) e = 1'b1;
      chk($sformatf("hold decr_pulse e%0d", k), decr_pulse, e);
      chk($sformatf("hold incr_pulse e%0d", k), incr_pulse, 0);
    end

    // Conflict: both held, decr released from edge 41; decr_level falls at 46.
    do_reset();
    btn_incr_raw = 1'b1;
    btn_decr_raw = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      if (k == 41) btn_decr_raw = 1'b0;
      step();
      chk($sformatf("conflict decr_level e%0d", k), decr_level, (k >= 6) && (k < 46));
      chk($sformatf("conflict decr_pulse e%0d", k), decr_pulse, 0);
      chk($sformatf("conflict incr_pulse e%0d", k), incr_pulse, (k >= 46) && (((k - 22) % REP) == 0));
    end

    // Reset mid-repeat: outputs drop without a clock edge; re-press counted from release.
    do_reset();
    btn_incr_raw = 1'b1;
    repeat (35) step();
    chk("midrep level before reset", incr_level, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrep async outs", {incr_pulse, decr_pulse, incr_level, decr_level}, 0);
    repeat (3) step();
    chk("midrep held outs", {incr_pulse, decr_pulse, incr_level, decr_level}, 0);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("midrep incr_pulse e%0d", k), incr_pulse, k == 6);
      chk($sformatf("midrep incr_level e%0d", k), incr_level, k >= 6);
    end

    // Random raw inputs against the edge-indexed model.
    do_reset();
    for (int ch = 0; ch < 2; ch++) begin
      rr[ch][0]      = 1'b0;
      m_stable[ch]   = 1'b0;
      m_last_acc[ch] = 0;
      m_press[ch]    = 0;
      hold_left[ch]  = 0;
      cur[ch]        = 1'b0;
    end
    for (int k = 1; k <= NR; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (hold_left[ch] == 0) begin
          cur[ch] = 1'($urandom_range(0, 1));
          hold_left[ch] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 60))
                                                      : int'($urandom_range(1, 6));
        end
        hold_left[ch]--;
        rr[ch][k] = cur[ch];
      end
      btn_incr_raw = rr[0][k];
      btn_decr_raw = rr[1][k];
      step();
      for (int ch = 0; ch < 2; ch++) begin
        // Accept when the last DB synchronized samples since the previous accept all differ.
        if (k - m_last_acc[ch] >= DB) begin
          all_diff = 1'b1;
          for (int i = 0; i < DB; i++) begin
            j = k - 2 - i;
            s = (j >= 1) ? rr[ch][j] : 1'b0;
            if (s == m_stable[ch]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_stable[ch]   = ~m_stable[ch];
            m_last_acc[ch] = k;
            if (m_stable[ch]) m_press[ch] = k;
          end
        end
        m_pulse[ch] = m_stable[ch] &&
                      ((k == m_press[ch]) ||
                       ((HLD > 0) && (k - m_press[ch] >= HLD) && (((k - m_press[ch] - HLD) % REP) == 0)));
      end
      chk($sformatf("rand incr_level e%0d", k), incr_level, m_stable[0]);
      chk($sformatf("rand decr_level e%0d", k), decr_level, m_stable[1]);
      chk($sformatf("rand incr_pulse e%0d", k), incr_pulse, m_pulse[0] && !(m_stable[0] && m_stable[1]));
      chk($sformatf("rand decr_pulse e%0d", k), decr_pulse, m_pulse[1] && !(m_stable[0] && m_stable[1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
